// File: rtl/wgt_rd_ctrl.sv
// -----------------------------------------------------------------------------
// wgt_rd_ctrl : read-side sequencer for the weight FIFO array.
//
// Drives per-lane FIFO read enables so that weights enter the systolic array
// diagonally (lane i lags lane 0 by i cycles). The same weight set is replayed
// for a programmable number of passes, and rd_clr rewinds the FIFO read
// pointers between passes. data_vld is rd_en delayed by the FIFO read latency.
//
// Optional build macro: WGT_RD_PAUSE_EN
//   Adds a 'pause' input. While pause=1 the sequencer freezes (FSM, counters
//   and stagger register hold) and rd_en / rd_clr / done are forced low.
//   Without the macro the port is absent and the sequence never stalls.
// -----------------------------------------------------------------------------
module wgt_rd_ctrl #(
  parameter int NUM_FIFO   = 16,
  parameter int LEN_WIDTH  = 13,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef WGT_RD_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  input  logic [4:0]            read_wgt_size,
  input  logic [PASS_WIDTH-1:0] num_pass,
  output logic [NUM_FIFO-1:0]   rd_en,
  output logic                  rd_clr,
  output logic [NUM_FIFO-1:0]   data_vld,
  output logic                  busy,
  output logic                  done
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CLR   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]            state, state_d;
  logic [LEN_WIDTH-1:0]  len_q;        // latched L
  logic [4:0]            lanes_q;      // latched N (1..NUM_FIFO)
  logic [PASS_WIDTH-1:0] pass_q;       // latched P (>= 1)
  logic [LEN_WIDTH-1:0]  cnt, cnt_d;   // cycles spent in RUN or DRAIN
  logic [PASS_WIDTH-1:0] pass_cnt, pass_cnt_d;
  logic                  latch;

  // Stagger register holds lanes 1..NUM_FIFO-1; lane 0 comes straight from
  // the FSM so the first enable appears in the cycle right after start.
  logic [NUM_FIFO-2:0]   tail;
  logic [NUM_FIFO-1:0]   lanes;
  logic [NUM_FIFO-1:0]   lane_mask;
  logic                  head;
  logic                  stall;

  logic [4:0]            lanes_in;
  logic [PASS_WIDTH-1:0] pass_in;
  logic [LEN_WIDTH-1:0]  last_len;
  logic [LEN_WIDTH-1:0]  last_drain;
  logic [2:0]            pass_end;

`ifdef WGT_RD_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  // Sanitise the request fields: out-of-range lane counts mean "all lanes",
  // a zero pass count means a single pass.
  assign lanes_in = (read_wgt_size == 5'd0 || read_wgt_size > 5'(NUM_FIFO))
                    ? 5'(NUM_FIFO) : read_wgt_size;
  assign pass_in  = (num_pass == '0) ? PASS_WIDTH'(1) : num_pass;

  // Terminal counts. RUN is only entered with L >= 1 and DRAIN only with N >= 2,
  // so neither subtraction underflows when it is used.
  assign last_len   = len_q - LEN_WIDTH'(1);
  assign last_drain = LEN_WIDTH'(lanes_q) - LEN_WIDTH'(2);
  assign pass_end   = (pass_cnt == pass_q - PASS_WIDTH'(1)) ? S_FIN : S_CLR;

  // Next-state and counter logic for the pass sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which is what keeps this block from inferring latches.
    state_d    = state;
    cnt_d      = cnt;
    pass_cnt_d = pass_cnt;
    latch      = 1'b0;
    if (!stall) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            latch      = 1'b1;
            cnt_d      = '0;
            pass_cnt_d = '0;
            state_d    = (rd_len == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == last_len) begin
            cnt_d   = '0;
            state_d = (lanes_q == 5'd1) ? pass_end : S_DRAIN;
          end else begin
            cnt_d = cnt + LEN_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == last_drain) begin
            cnt_d   = '0;
            state_d = pass_end;
          end else begin
            cnt_d = cnt + LEN_WIDTH'(1);
          end
        end
        S_CLR: begin
          pass_cnt_d = pass_cnt + PASS_WIDTH'(1);
          state_d    = S_RUN;
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM, counters and latched request parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pass_cnt <= '0;
      len_q    <= '0;
      lanes_q  <= 5'(NUM_FIFO);
      pass_q   <= PASS_WIDTH'(1);
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pass_cnt <= pass_cnt_d;
      if (latch) begin
        len_q   <= rd_len;
        lanes_q <= lanes_in;
        pass_q  <= pass_in;
      end
    end
  end

  // Lane mask: lanes at or above N are never enabled.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      lane_mask[i] = (i < int'(lanes_q));
    end
  end

  assign head  = (state == S_RUN);
  assign lanes = {tail, head};

  // Stagger shift: each lane repeats the lane below it one cycle later.
  // Masking on entry keeps inactive lanes empty, so a following request with
  // a wider lane count never sees leftovers from a narrower one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail <= '0;
    end else if (!stall) begin
      tail <= lanes[NUM_FIFO-2:0] & lane_mask[NUM_FIFO-1:1];
    end
  end

  // Output decode; a stall silences the strobes but keeps busy asserted.
  always_comb begin
    rd_en  = stall ? '0 : (lanes & lane_mask);
    rd_clr = !stall && (state == S_CLR);
    done   = !stall && (state == S_FIN);
    busy   = (state != S_IDLE);
  end

  // FIFO data becomes valid one cycle after its read enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld <= '0;
    end else begin
      data_vld <= rd_en;
    end
  end

  // Structural invariants of the sequence.
  a_clr_no_rd : assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_clr && (|rd_en)));
  a_clr_no_done : assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_clr && done));

endmodule

// File: tb/tb_wgt_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wgt_rd_ctrl : self-checking bench for wgt_rd_ctrl (default build).
// A cycle-indexed reference model derives every output from the request
// (L, N, P) and the cycle number since acceptance; a compare process checks
// all outputs every cycle. Directed scenarios pin the model with literals,
// then randomized requests (with spurious start pulses) exercise the rest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wgt_rd_ctrl;

  localparam int NF = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [12:0]   rd_len = '0;
  logic [4:0]    read_wgt_size = '0;
  logic [7:0]    num_pass = '0;
  logic [NF-1:0] rd_en;
  logic          rd_clr;
  logic [NF-1:0] data_vld;
  logic          busy;
  logic          done;

  int n_err = 0;
  int n_checks = 0;

  wgt_rd_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .rd_len        (rd_len),
    .read_wgt_size (read_wgt_size),
    .num_pass      (num_pass),
    .rd_en         (rd_en),
    .rd_clr        (rd_clr),
    .data_vld      (data_vld),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit  m_active = 0;
  int  m_k = 0;          // cycle number within the current request (1-based)
  int  m_l, m_n, m_p, m_total;
  logic [NF-1:0] m_vld = '0;

  // Lane enables expected in cycle k of the current request.
  function automatic logic [NF-1:0] exp_rd(int k);
    int t, p, c;
    exp_rd = '0;
    if (m_l == 0) return exp_rd;
    t = m_l + m_n;
    p = (k - 1) / t;
    c = (k - 1) % t + 1;
    if (p >= m_p) return exp_rd;
    for (int i = 0; i < m_n; i++)
      if (c >= 1 + i && c <= m_l + i) exp_rd[i] = 1'b1;
  endfunction

  function automatic bit exp_clr(int k);
    int t;
    if (m_l == 0) return 1'b0;
    t = m_l + m_n;
    return ((k % t) == 0) && ((k / t) < m_p);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_k = 0;
      m_vld = '0;
    end else begin
      m_vld = m_active ? exp_rd(m_k) : '0;
      if (m_active) begin
        if (m_k == m_total) m_active = 0;
        else m_k++;
      end else if (start) begin
        m_l = int'(rd_len);
        m_n = (read_wgt_size == 0 || read_wgt_size > NF) ? NF : int'(read_wgt_size);
        m_p = (num_pass == 0) ? 1 : int'(num_pass);
        m_total = (m_l == 0) ? 1 : m_p * (m_l + m_n);
        m_active = 1;
        m_k = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rd_en",    32'(rd_en),    32'(m_active ? exp_rd(m_k) : '0));
    check("data_vld", 32'(data_vld), 32'(m_vld));
    check("rd_clr",   32'(rd_clr),   32'(m_active && exp_clr(m_k)));
    check("done",     32'(done),     32'(m_active && m_k == m_total));
    check("busy",     32'(busy),     32'(m_active));
  end

  // ---------------- stimulus ----------------
  // Issue one request and follow it to done. restart_cyc>0 pulses start in
  // that cycle; rnd_start drives random start pulses throughout the run.
  task automatic run_seq(input int l, input int n, input int p, input int lane,
                         input int restart_cyc, input bit rnd_start,
                         output int done_cyc, output int clr_cnt, output int lane_cnt);
    @(posedge clk); #1;
    rd_len = 13'(l);
    read_wgt_size = 5'(n);
    num_pass = 8'(p);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = 0;
    clr_cnt = 0;
    lane_cnt = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (rd_clr) clr_cnt++;
      if (rd_en[lane]) lane_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
      start = rnd_start ? ($urandom_range(0, 2) == 0) : (c + 1 == restart_cyc);
    end
    start = 1'b0;
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  int dc, cc, lc, extra;

  initial begin
    #12;
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;

    // L=4, N=16, P=1
    run_seq(4, 16, 1, 15, 0, 0, dc, cc, lc);
    check("t1_done_cyc", 32'(dc), 32'd20);
    check("t1_clr_cnt", 32'(cc), 32'd0);
    check("t1_lane15_cnt", 32'(lc), 32'd4);

    // L=3, N=4, P=3
    run_seq(3, 4, 3, 3, 0, 0, dc, cc, lc);
    check("t2_done_cyc", 32'(dc), 32'd21);
    check("t2_clr_cnt", 32'(cc), 32'd2);
    check("t2_lane3_cnt", 32'(lc), 32'd9);

    // L=0, N=8: immediate done, no enables
    run_seq(0, 8, 1, 0, 0, 0, dc, cc, lc);
    check("t3_done_cyc", 32'(dc), 32'd1);
    check("t3_lane0_cnt", 32'(lc), 32'd0);

    // read_wgt_size=0 behaves as N=16
    run_seq(2, 0, 1, 15, 0, 0, dc, cc, lc);
    check("t3b_done_cyc", 32'(dc), 32'd18);
    check("t3b_lane15_cnt", 32'(lc), 32'd2);

    // start re-pulsed at cycle 3 is ignored
    run_seq(5, 2, 1, 1, 3, 0, dc, cc, lc);
    check("t5_done_cyc", 32'(dc), 32'd7);
    check("t5_lane1_cnt", 32'(lc), 32'd5);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t5_extra_done", 32'(extra), 32'd0);

    // Asynchronous reset mid-sequence (L=10, N=16)
    @(posedge clk); #1;
    rd_len = 13'd10;
    read_wgt_size = 5'd16;
    num_pass = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t4_rd_en_c5", 32'(rd_en), 32'h1F);
    check("t4_vld_c5", 32'(data_vld), 32'h0F);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_rd_en", 32'(rd_en), 32'd0);
    check("t4_rst_vld", 32'(data_vld), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_clr_done", 32'({rd_clr, done}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    run_seq(4, 5, 2, 4, 0, 0, dc, cc, lc);
    check("t4_post_done_cyc", 32'(dc), 32'd18);
    check("t4_post_clr_cnt", 32'(cc), 32'd1);
    check("t4_post_lane4_cnt", 32'(lc), 32'd8);

    // Randomized requests with spurious start pulses while busy
    for (int r = 0; r < 25; r++) begin
      run_seq(int'($urandom_range(0, 12)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, NF - 1)),
              0, 1, dc, cc, lc);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
